bash_f_iter: RTL and testbench
==============================

Name: bash_f_iter

Overview:
- Iterative bash-f sponge permutation (STB 34.101.77) over a 1536-bit state of 24 x 64-bit words.
- Successor of the single-column fixed-rotation S-box: LANES columns are processed per cycle through runtime-rotation S-box instances, followed by word permutation P and round-constant injection, for 24 rounds.
- Sits between the bash sponge controller (absorb/squeeze) and the state register file; valid/ready on both sides.

Parameters:
- LANES, 2, number of S-box columns evaluated per cycle; legal values 1, 2, 4, 8; STEPS = 8/LANES.
- ROUNDS, 24, number of rounds; 24 for standard bash-f, smaller values for debug only.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input state presented
- in_ready_o  out  1  block can accept a state
- state_i  in  1536  input state; word k at bits [64k+63:64k]; words in the same byte order as the bash S-box
- out_valid_o  out  1  permuted state available
- out_ready_i  in  1  consumer accepts output
- state_o  out  1536  permuted state, same packing
- busy_o  out  1  permutation in progress

Behaviour:
- Reset, applied on any cycle including mid-permutation: FSM returns to IDLE; in_ready_o=1, out_valid_o=0, busy_o=0; state register, step counter and round counter are cleared to 0; any in-flight work is discarded.
- IDLE: in_ready_o=1. When in_valid_i is high, load state_i and go to RUN with round=0, step=0.
- RUN: in_ready_o=0, busy_o=1.
  - Each cycle, columns j = step*LANES .. step*LANES+LANES-1 are updated in place.
  - For each column, (S[j], S[8+j], S[16+j]) pass through the S-box using rotation set j.
  - When step=STEPS-1, the same cycle also applies S <- S[P] to the already-updated words, then S[23] ^= RC[round].
  - Then step wraps to 0 and round increments.
  - After the final step of round ROUNDS-1, go to DONE.
- DONE: out_valid_o=1, state_o=state register; state_o is held stable until out_ready_i. On out_valid_o & out_ready_i, go to IDLE.
- Latency: load cycle to out_valid_o is exactly ROUNDS*STEPS+1 cycles. LANES=2: 97; LANES=8: 25; LANES=1: 193.
- No pipelining across permutations; throughput is one state per ROUNDS*STEPS+2 cycles minimum.
- Rotation set j (m1, n1, m2, n2):
  - j=0: 8, 53, 14, 1
  - j=1: 56, 51, 34, 7
  - j=2: 8, 37, 46, 49
  - j=3: 56, 3, 2, 23
  - j=4: 8, 21, 14, 33
  - j=5: 56, 19, 34, 39
  - j=6: 8, 5, 46, 17
  - j=7: 56, 35, 2, 55
- Rotations are cyclic left shifts applied to the byte-reversed word, then reversed back, exactly as in the existing S-box. Rotation amount 0 is never used.
- P (destination i takes source P[i]): 15,10,9,12,11,14,13,8, 17,16,19,18,21,20,23,22, 6,3,0,7,2,5,4,1.
- state_i is ignored outside IDLE. in_valid_i held high in DONE does not start a new permutation until IDLE is re-entered.

Decomposition:
- Package bash_pkg holds:
  - STATE_WORDS=24, WORD_W=64
  - rot_set_t struct {m1, n1, m2, n2: 6 bits each}
  - ROT_TABLE[8]
  - PERM_P[24]
  - RC[24], with RC[0] = 0xB194BAC80A08F53B in state-word byte order, entries per STB 34.101.77
  - FSM state enum {IDLE, RUN, DONE}
- Sub-module bash_s_var: bash S-box with m1/n1/m2/n2 as 6-bit input ports instead of parameters; instantiated LANES times.
- The top holds the FSM, counters, column mux/demux, P and the RC XOR.

Test Plan:
- KAT, LANES=2: all-zero state in, 24 rounds -> state_o equals STB 34.101.77 Table A.1 bash-f output; out_valid_o exactly 97 cycles after load.
- Lane equivalence: the same random states through LANES=1, 2, 4, 8 -> identical state_o; latencies 193, 97, 49, 25.
- Backpressure: out_ready_i held low for 10 cycles in DONE -> state_o stable, in_ready_o=0 throughout; handshake on cycle 11, IDLE next cycle.
- Reset mid-run: rst_i asserted at round 12 -> next cycle in_ready_o=1, out_valid_o=0, busy_o=0; a fresh KAT afterwards passes.
- ROUNDS=1 debug build, all-zero input -> only S[23] differs from the pure S-box+P result, by RC[0]; latency STEPS+1.
- Back-to-back: two states with in_valid_i held high and out_ready_i=1 -> two correct outputs; the second load occurs in the cycle after the first output handshake.

Source files
------------

// File: rtl/bash_pkg.sv
// Shared constants and types for the iterative bash-f permutation.
package bash_pkg;

  localparam int unsigned STATE_WORDS = 24;
  localparam int unsigned WORD_W      = 64;

  typedef struct packed {
    logic [5:0] m1;
    logic [5:0] n1;
    logic [5:0] m2;
    logic [5:0] n2;
  } rot_set_t;

  // Per-column rotation amounts, indexed by column j
  localparam rot_set_t ROT_TABLE [8] = '{
    '{6'd8,  6'd53, 6'd14, 6'd1 },
    '{6'd56, 6'd51, 6'd34, 6'd7 },
    '{6'd8,  6'd37, 6'd46, 6'd49},
    '{6'd56, 6'd3,  6'd2,  6'd23},
    '{6'd8,  6'd21, 6'd14, 6'd33},
    '{6'd56, 6'd19, 6'd34, 6'd39},
    '{6'd8,  6'd5,  6'd46, 6'd17},
    '{6'd56, 6'd35, 6'd2,  6'd55}
  };

  // Word permutation: destination i takes source PERM_P[i]
  localparam int unsigned PERM_P [24] = '{
    15, 10,  9, 12, 11, 14, 13,  8,
    17, 16, 19, 18, 21, 20, 23, 22,
     6,  3,  0,  7,  2,  5,  4,  1
  };

  function automatic logic [63:0] bswap64(input logic [63:0] w);
    for (int unsigned b = 0; b < 8; b++) begin
      bswap64[8*b +: 8] = w[8*(7-b) +: 8];
    end
  endfunction

  // Round constants are produced by the standard's Galois LFSR on the numeric
  // value, then stored byte-reversed to match the state-word packing.
  function automatic logic [STATE_WORDS-1:0][WORD_W-1:0] gen_rc();
    logic [63:0] c;
    c = 64'h3BF5080AC8BA94B1;
    for (int unsigned i = 0; i < STATE_WORDS; i++) begin
      gen_rc[i] = bswap64(c);
      c = {1'b0, c[63:1]} ^ (c[0] ? 64'hDC2BE1997FE0D8AE : 64'h0);
    end
  endfunction

  // RC[0] = 0xB194BAC80A08F53B in state-word byte order
  localparam logic [STATE_WORDS-1:0][WORD_W-1:0] RC = gen_rc();

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

endpackage

// File: rtl/bash_s_var.sv
// bash S-box with rotation amounts supplied at runtime.
module bash_s_var (
  input  logic [63:0] w0,
  input  logic [63:0] w1,
  input  logic [63:0] w2,
  input  logic [5:0]  m1,
  input  logic [5:0]  n1,
  input  logic [5:0]  m2,
  input  logic [5:0]  n2,
  output logic [63:0] y0,
  output logic [63:0] y1,
  output logic [63:0] y2
);
  import bash_pkg::*;

  logic [63:0] x0, x1, x2;
  logic [63:0] t0, t1, u0, u1, u2;

  function automatic logic [63:0] rotl(input logic [63:0] x, input logic [5:0] r);
    rotl = (x << r) | (x >> (7'd64 - {1'b0, r}));
  endfunction

  // Byte-swap once on entry/exit so rotations act on the numeric value;
  // the remaining operations are bitwise and unaffected by byte order.
  always_comb begin
    x0 = bswap64(w0);
    x1 = bswap64(w1);
    x2 = bswap64(w2);
    t0 = rotl(x0, m1);
    u0 = x0 ^ x1 ^ x2;
    t1 = x1 ^ rotl(u0, n1);
    u1 = t0 ^ t1;
    u2 = x2 ^ rotl(x2, m2) ^ rotl(t1, n2);
    y0 = bswap64(u0 ^ (~u2 | u1));
    y1 = bswap64(u1 ^ (u0 | u2));
    y2 = bswap64(u2 ^ (u0 & u1));
  end

endmodule

// File: rtl/bash_f_iter.sv
// Iterative bash-f permutation: LANES S-box columns per cycle, P and RC on the last step of each round.
module bash_f_iter
  import bash_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ROUNDS = 24
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [STATE_WORDS*WORD_W-1:0]   state_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [STATE_WORDS*WORD_W-1:0]   state_o,
  output logic                            busy_o
);

  localparam int unsigned STEPS      = 8 / LANES;
  localparam logic [2:0]  LAST_STEP  = 3'(STEPS - 1);
  localparam logic [4:0]  LAST_ROUND = 5'(ROUNDS - 1);

  fsm_t fsm;
  logic [STATE_WORDS-1:0][WORD_W-1:0] st, st_cols, st_perm, st_next;
  logic [2:0] step;
  logic [4:0] round;

  logic [LANES-1:0][2:0]  col;
  logic [LANES-1:0][63:0] a0, a1, a2, b0, b1, b2;

  assign state_o = st;

  // Column mux into the S-box lanes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign col[l] = 3'(32'(step) * LANES + l);
    assign a0[l]  = st[{2'b00, col[l]}];
    assign a1[l]  = st[5'd8  + {2'b00, col[l]}];
    assign a2[l]  = st[5'd16 + {2'b00, col[l]}];

    bash_s_var u_sbox (
      .w0 (a0[l]),
      .w1 (a1[l]),
      .w2 (a2[l]),
      .m1 (ROT_TABLE[col[l]].m1),
      .n1 (ROT_TABLE[col[l]].n1),
      .m2 (ROT_TABLE[col[l]].m2),
      .n2 (ROT_TABLE[col[l]].n2),
      .y0 (b0[l]),
      .y1 (b1[l]),
      .y2 (b2[l])
    );
  end

  // Demux is written per word so every select is a constant: word w belongs to
  // step w/LANES and is served by lane w%LANES.
  for (genvar w = 0; w < 8; w++) begin : g_col
    localparam int unsigned LN  = w % LANES;
    localparam logic [2:0]  GRP = 3'(w / LANES);
    assign st_cols[w]      = (step == GRP) ? b0[LN] : st[w];
    assign st_cols[8 + w]  = (step == GRP) ? b1[LN] : st[8 + w];
    assign st_cols[16 + w] = (step == GRP) ? b2[LN] : st[16 + w];
  end

  for (genvar i = 0; i < STATE_WORDS; i++) begin : g_perm
    assign st_perm[i] = st_cols[PERM_P[i]];
  end

  // Next state: column update, plus P and RC injection on the round's last step
  always_comb begin
    st_next = st_cols;
    if (step == LAST_STEP) begin
      st_next     = st_perm;
      st_next[23] = st_perm[23] ^ RC[round];
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm         <= IDLE;
      st          <= '0;
      step        <= '0;
      round       <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid_i) begin
            st         <= state_i;
            step       <= '0;
            round      <= '0;
            fsm        <= RUN;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        RUN: begin
          st <= st_next;
          if (step == LAST_STEP) begin
            step <= '0;
            if (round == LAST_ROUND) begin
              fsm         <= DONE;
              busy_o      <= 1'b0;
              out_valid_o <= 1'b1;
            end else begin
              round <= round + 5'd1;
            end
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            fsm         <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: begin
          fsm         <= IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bash_f_iter.sv
// Self-checking bench for bash_f_iter against a word-level bash-f reference model.
module tb_bash_f_iter;

  localparam int W = 1536;
  localparam int LIMIT = 300;

  logic clk;
  logic rst;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] state_in, state_out;

  logic         in_valid_x;
  logic [W-1:0] state_x;
  logic         out_ready_x;
  logic         ir1, ov1, bz1, ir4, ov4, bz4, ir8, ov8, bz8, irr, ovr, bzr;
  logic [W-1:0] so1, so4, so8, sor;

  int n_pass;
  int n_total;

  bash_f_iter #(.LANES(2), .ROUNDS(24)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .state_i(state_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .state_o(state_out), .busy_o(busy));

  bash_f_iter #(.LANES(1), .ROUNDS(24)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(ir1),
    .state_i(state_x), .out_valid_o(ov1), .out_ready_i(out_ready_x),
    .state_o(so1), .busy_o(bz1));

  bash_f_iter #(.LANES(4), .ROUNDS(24)) dut_l4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(ir4),
    .state_i(state_x), .out_valid_o(ov4), .out_ready_i(out_ready_x),
    .state_o(so4), .busy_o(bz4));

  bash_f_iter #(.LANES(8), .ROUNDS(24)) dut_l8 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(ir8),
    .state_i(state_x), .out_valid_o(ov8), .out_ready_i(out_ready_x),
    .state_o(so8), .busy_o(bz8));

  bash_f_iter #(.LANES(2), .ROUNDS(1)) dut_r1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_x), .in_ready_o(irr),
    .state_i(state_x), .out_valid_o(ovr), .out_ready_i(out_ready_x),
    .state_o(sor), .busy_o(bzr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (numeric word domain) ----------------
  int rot_tab [8][4] = '{
    '{8, 53, 14, 1}, '{56, 51, 34, 7}, '{8, 37, 46, 49}, '{56, 3, 2, 23},
    '{8, 21, 14, 33}, '{56, 19, 34, 39}, '{8, 5, 46, 17}, '{56, 35, 2, 55}};
  int perm [24] = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18, 21, 20, 23, 22,
                    6, 3, 0, 7, 2, 5, 4, 1};

  function automatic logic [63:0] bsw(input logic [63:0] w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [W-1:0] model_f(input logic [W-1:0] s_in, input int rounds,
                                           input bit use_rc);
    logic [63:0] w [24];
    logic [63:0] nw [24];
    logic [63:0] c, a, b, d, t0, t1;
    logic [W-1:0] res;
    for (int k = 0; k < 24; k++) w[k] = bsw(s_in[64*k +: 64]);
    c = 64'h3BF5080AC8BA94B1;
    for (int r = 0; r < rounds; r++) begin
      for (int j = 0; j < 8; j++) begin
        a = w[j]; b = w[8+j]; d = w[16+j];
        t0 = rl(a, rot_tab[j][0]);
        a = a ^ b ^ d;
        t1 = b ^ rl(a, rot_tab[j][1]);
        b = t0 ^ t1;
        d = d ^ rl(d, rot_tab[j][2]) ^ rl(t1, rot_tab[j][3]);
        w[j]    = a ^ (~d | b);
        w[8+j]  = b ^ (a | d);
        w[16+j] = d ^ (a & b);
      end
      for (int i = 0; i < 24; i++) nw[i] = w[perm[i]];
      w = nw;
      if (use_rc) w[23] = w[23] ^ c;
      c = (c >> 1) ^ (c[0] ? 64'hDC2BE1997FE0D8AE : 64'h0);
    end
    for (int k = 0; k < 24; k++) res[64*k +: 64] = bsw(w[k]);
    return res;
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [W-1:0] r;
    for (int i = 0; i < 48; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int k;
    k = 0;
    for (int i = 23; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) k = i;
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed word%0d=%h required %h", tag, k,
                obs[64*k +: 64], exp[64*k +: 64]);
  endtask

  // Present a state for one load edge; returns at the first negedge after it.
  task automatic main_load(input logic [W-1:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    state_in = s;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    state_in = rand_state();
  endtask

  // Called at the first negedge after the load edge; latency counts that as 1.
  task automatic wait_main(output int lat);
    lat = 1;
    while (!out_valid && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic aux_run(input logic [W-1:0] s, input string tag);
    int lat [4];
    logic [W-1:0] got [4];
    bit seen [4];
    logic [W-1:0] e24, e1, enorc, rcdiff;
    int n;
    for (int i = 0; i < 4; i++) begin lat[i] = 0; seen[i] = 1'b0; got[i] = '0; end
    @(negedge clk);
    in_valid_x = 1'b1;
    state_x = s;
    @(posedge clk);
    @(negedge clk);
    in_valid_x = 1'b0;
    state_x = rand_state();
    n = 1;
    while (n <= LIMIT && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
      if (!seen[0] && ov1) begin seen[0] = 1'b1; lat[0] = n; got[0] = so1; end
      if (!seen[1] && ov4) begin seen[1] = 1'b1; lat[1] = n; got[1] = so4; end
      if (!seen[2] && ov8) begin seen[2] = 1'b1; lat[2] = n; got[2] = so8; end
      if (!seen[3] && ovr) begin seen[3] = 1'b1; lat[3] = n; got[3] = sor; end
      @(negedge clk);
      n++;
    end
    e24   = model_f(s, 24, 1'b1);
    e1    = model_f(s, 1, 1'b1);
    enorc = model_f(s, 1, 1'b0);
    rcdiff = '0;
    rcdiff[64*23 +: 64] = 64'hB194BAC80A08F53B;
    check({tag, "_l1_state"}, got[0], e24);
    check({tag, "_l1_lat"}, W'(lat[0]), W'(193));
    check({tag, "_l4_state"}, got[1], e24);
    check({tag, "_l4_lat"}, W'(lat[1]), W'(49));
    check({tag, "_l8_state"}, got[2], e24);
    check({tag, "_l8_lat"}, W'(lat[2]), W'(25));
    check({tag, "_r1_state"}, got[3], e1);
    check({tag, "_r1_lat"}, W'(lat[3]), W'(5));
    check({tag, "_r1_rc_only_w23"}, got[3] ^ enorc, rcdiff);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [W-1:0] s, sa, sb, first;
    bit stable;

    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    state_in = '0;
    out_ready = 1'b1;
    in_valid_x = 1'b0;
    state_x = '0;
    out_ready_x = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_state", state_out, '0);
    rst = 1'b0;

    // KAT on the all-zero state
    main_load('0);
    check("kat_busy", W'(busy), W'(1));
    check("kat_in_ready_low", W'(in_ready), W'(0));
    wait_main(lat);
    check("kat_lat", W'(lat), W'(97));
    check("kat_state", state_out, model_f('0, 24, 1'b1));
    @(negedge clk);
    check("kat_idle_in_ready", W'(in_ready), W'(1));
    check("kat_idle_out_valid", W'(out_valid), W'(0));

    // Backpressure: consumer stalls 10 cycles in DONE, accepts on the 11th
    out_ready = 1'b0;
    s = rand_state();
    main_load(s);
    wait_main(lat);
    check("bp_lat", W'(lat), W'(97));
    check("bp_state", state_out, model_f(s, 24, 1'b1));
    first = state_out;
    stable = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      if (state_out !== first || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_held_stable", W'(stable), W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_in_ready", W'(in_ready), W'(1));
    check("bp_idle_out_valid", W'(out_valid), W'(0));

    // Reset in the middle of round 12, then a fresh KAT
    main_load(rand_state());
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", W'(in_ready), W'(1));
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_state", state_out, '0);
    rst = 1'b0;
    main_load('0);
    wait_main(lat);
    check("midrst_kat_lat", W'(lat), W'(97));
    check("midrst_kat_state", state_out, model_f('0, 24, 1'b1));
    @(negedge clk);

    // Back-to-back with in_valid held high
    sa = rand_state();
    sb = rand_state();
    out_ready = 1'b1;
    in_valid = 1'b1;
    state_in = sa;
    @(posedge clk);
    @(negedge clk);
    state_in = sb;
    wait_main(lat);
    check("b2b_a_lat", W'(lat), W'(97));
    check("b2b_a_state", state_out, model_f(sa, 24, 1'b1));
    @(negedge clk);
    check("b2b_idle_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    state_in = rand_state();
    check("b2b_b_busy", W'(busy), W'(1));
    wait_main(lat);
    check("b2b_b_lat", W'(lat), W'(97));
    check("b2b_b_state", state_out, model_f(sb, 24, 1'b1));
    @(negedge clk);

    // Lane equivalence and ROUNDS=1 debug build
    aux_run('0, "zero");
    aux_run(rand_state(), "rnd0");
    aux_run(rand_state(), "rnd1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
